load_store_unit: RTL and testbench

// - CPU-side initiator for the word-wide data memory port (data_address/write_data/write_enable/read_data).
// - Accepts byte/half/word load-store requests from the execute stage; word-only memory, so sub-word stores use read-modify-write.
// - Performs little-endian lane select, sign/zero extension, alignment and range checks; returns one response per request.

---
 rtl/load_store_unit_pkg.sv | 31 +++
 rtl/load_store_unit_lane_align.sv | 43 ++++
 rtl/load_store_unit.sv | 137 +++++++++++++
 tb/tb_load_store_unit.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the helper that classifies a request shape as legal or not.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } state_e;

    // A lane index times 8 gives the bit offset of that byte within the word.
    localparam int LANE_SHIFT = 3;

    function automatic logic is_bad_shape(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lane[0];
            SZ_WORD: return lane != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane logic: extracts and extends load data from a memory word,
// and merges right-justified store data into a memory word.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data
);

    logic [4:0]  w_shift;
    logic [15:0] w_lane_data;
    logic [31:0] w_mask;
    logic [31:0] w_ins_data;

    assign w_shift     = 5'(i_lane) << LANE_SHIFT;
    assign w_lane_data = 16'(i_rdata >> w_shift);
    assign w_ins_data  = i_wdata << w_shift;

    always_comb begin
        o_load_data = i_rdata;
        w_mask      = 32'hFFFF_FFFF;
        case (i_size)
            SZ_BYTE: begin
                o_load_data = {{24{i_signed & w_lane_data[7]}}, w_lane_data[7:0]};
                w_mask      = 32'h0000_00FF << w_shift;
            end
            SZ_HALF: begin
                o_load_data = {{16{i_signed & w_lane_data[15]}}, w_lane_data};
                w_mask      = 32'h0000_FFFF << w_shift;
            end
            default: ;
        endcase
    end

    // Unselected lanes keep the word that was read; selected lanes take new data.
    assign o_merge_data = (i_rdata & ~w_mask) | (w_ins_data & w_mask);

endmodule

// File: rtl/load_store_unit.sv
// CPU-side initiator for a word-wide data memory: one request at a time,
// sub-word stores done as read-modify-write, one response per request.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] data_address,
    output logic [31:0] write_data,
    output logic        write_enable,
    input  logic [31:0] read_data
);

    state_e            r_state;
    state_e            w_next_state;
    logic              r_write;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [1:0]        r_lane;
    logic [31:0]       r_wdata;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_write_data;
    logic              r_write_enable;
    logic [31:0]       r_resp_rdata;
    logic              r_resp_error;
    logic              w_accept;
    logic              w_req_error;
    logic [31:0]       w_load_data;
    logic [31:0]       w_merge_data;

    assign w_accept    = req_valid && req_ready;
    assign w_req_error = (req_addr[31:ADDR_W+2] != '0) || is_bad_shape(req_size, req_addr[1:0]);

    lsu_lane_align u_align (
        .i_size       (r_size),
        .i_signed     (r_signed),
        .i_lane       (r_lane),
        .i_rdata      (read_data),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_req_error) begin
                        w_next_state = ST_RESP;
                    end else if (!req_write || req_size != SZ_WORD) begin
                        w_next_state = ST_READ;
                    end else begin
                        w_next_state = ST_WRITE;
                    end
                end
            end
            ST_READ:  w_next_state = r_write ? ST_WRITE : ST_RESP;
            ST_WRITE: w_next_state = ST_RESP;
            ST_RESP:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == ST_IDLE);
        resp_valid = (r_state == ST_RESP);
    end

    // The memory address only moves on a legal accept, so nothing is read speculatively.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write        <= 1'b0;
            r_size         <= 2'b00;
            r_signed       <= 1'b0;
            r_lane         <= 2'b00;
            r_wdata        <= '0;
            r_addr         <= '0;
            r_write_data   <= '0;
            r_write_enable <= 1'b0;
            r_resp_rdata   <= '0;
            r_resp_error   <= 1'b0;
        end else begin
            r_write_enable <= (w_next_state == ST_WRITE);
            r_resp_rdata   <= '0;
            r_resp_error   <= 1'b0;
            if (w_accept) begin
                r_write      <= req_write;
                r_size       <= req_size;
                r_signed     <= req_signed;
                r_lane       <= req_addr[1:0];
                r_wdata      <= req_wdata;
                r_resp_error <= w_req_error;
                if (!w_req_error) begin
                    r_addr <= req_addr[ADDR_W+1:2];
                    if (req_write && req_size == SZ_WORD) begin
                        r_write_data <= req_wdata;
                    end
                end
            end
            if (r_state == ST_READ) begin
                if (r_write) begin
                    r_write_data <= w_merge_data;
                end else begin
                    r_resp_rdata <= w_load_data;
                end
            end
        end
    end

    assign data_address = {{(32-ADDR_W){1'b0}}, r_addr};
    assign write_data   = r_write_data;
    assign write_enable = r_write_enable;
    assign resp_rdata   = r_resp_rdata;
    assign resp_error   = r_resp_error;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a word memory that writes on the
// falling edge, a transaction-level reference model and a per-cycle comparator.
module tb_load_store_unit;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] data_address;
    logic [31:0] write_data;
    logic        write_enable;
    logic [31:0] read_data;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .data_address (data_address),
        .write_data   (write_data),
        .write_enable (write_enable),
        .read_data    (read_data)
    );

    // Data memory: asynchronous read, write sampled on the falling edge.
    logic [31:0] mem    [DEPTH];
    logic [31:0] refMem [DEPTH];

    assign read_data = mem[data_address[ADDR_W-1:0]];

    always @(negedge clk) begin
        if (write_enable) mem[data_address[ADDR_W-1:0]] = write_data;
    end

    typedef struct {
        int unsigned dueCyc;
        bit          hasWrite;
        int unsigned weCyc;
        logic [31:0] weAddr;
        logic [31:0] weData;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t              expQ[$];
    int                checks = 0;
    int                errors = 0;
    int unsigned       cyc = 0;
    bit                checking = 1'b0;
    logic [ADDR_W-1:0] modelAddr = '0;
    int                respCount = 0;
    int                weCount = 0;
    int unsigned       lastRespCyc = 0;
    int unsigned       lastAccept = 0;
    logic [31:0]       lastRespData = '0;
    logic              lastRespErr = 1'b0;
    logic [31:0]       lastWeAddr = '0;
    logic [31:0]       lastWeData = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: every falling edge, the outputs must match what the
    // outstanding transaction (if any) says should be happening this cycle.
    always @(negedge clk) begin : compareProc
        bit   expResp;
        bit   expWe;
        exp_t e;
        expResp = 1'b0;
        expWe   = 1'b0;
        if (resp_valid) begin
            respCount++;
            lastRespCyc  = cyc;
            lastRespData = resp_rdata;
            lastRespErr  = resp_error;
        end
        if (write_enable) begin
            weCount++;
            lastWeAddr = data_address;
            lastWeData = write_data;
        end
        if (checking) begin
            checkOutput("req_ready", {31'b0, req_ready}, {31'b0, expQ.size() == 0});
            checkOutput("data_address", data_address, 32'(modelAddr));
            if (expQ.size() > 0) begin
                e       = expQ[0];
                expResp = (e.dueCyc == cyc);
                expWe   = e.hasWrite && (e.weCyc == cyc);
            end
            checkOutput("write_enable", {31'b0, write_enable}, {31'b0, expWe});
            if (expWe) begin
                checkOutput("write_data", write_data, e.weData);
                refMem[e.weAddr[ADDR_W-1:0]] = e.weData;
            end
            checkOutput("resp_valid", {31'b0, resp_valid}, {31'b0, expResp});
            if (expResp) begin
                checkOutput("resp_rdata", resp_rdata, e.rdata);
                checkOutput("resp_error", {31'b0, resp_error}, {31'b0, e.err});
                void'(expQ.pop_front());
            end
        end
    end

    // Drive one request and hold it until accepted; the model entry is built
    // from the access rules just before the accepting edge.
    task automatic applyStimulus(input bit w, input logic [1:0] sz, input bit sgn,
                                 input logic [31:0] addr, input logic [31:0] wd);
        int          waitCnt;
        int          nbytes;
        int          lane;
        int          lat;
        bit          err;
        logic [31:0] word;
        logic [31:0] val;
        exp_t        e;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        #1;
        waitCnt = 0;
        while (!req_ready && waitCnt < 20) begin
            @(negedge clk);
            #1;
            waitCnt++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: req_ready=%0b after %0d cycles, required 1", req_ready, waitCnt);
            req_valid = 1'b0;
            return;
        end
        nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        lane   = int'(addr[1:0]);
        err    = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && lane != 0)
                 || (addr >= 32'(4 * DEPTH));
        word   = refMem[addr[ADDR_W+1:2]];
        e.hasWrite = 1'b0;
        e.weAddr   = 32'(addr[ADDR_W+1:2]);
        e.weData   = word;
        e.rdata    = '0;
        e.err      = err;
        if (err) begin
            lat = 1;
        end else if (!w) begin
            lat = 2;
            val = '0;
            for (int k = 0; k < nbytes; k++) val[8*k +: 8] = word[8*(lane+k) +: 8];
            if (sgn && nbytes < 4 && val[8*nbytes-1]) val = val | (32'hFFFF_FFFF << (8 * nbytes));
            e.rdata = val;
        end else begin
            lat = (nbytes == 4) ? 2 : 3;
            for (int k = 0; k < nbytes; k++) e.weData[8*(lane+k) +: 8] = wd[8*k +: 8];
            e.hasWrite = 1'b1;
        end
        e.dueCyc   = cyc + lat;
        e.weCyc    = cyc + lat - 1;
        lastAccept = cyc + 1;
        expQ.push_back(e);
        if (!err) modelAddr = addr[ADDR_W+1:2];
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        @(negedge clk);
        req_valid = 1'b0;
        while (expQ.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL response_timeout: %0d outstanding, required 0", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic runDirected(input string name, input bit w, input logic [1:0] sz, input bit sgn,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] expData, input bit expErr, input int expLat);
        int rc0;
        rc0 = respCount;
        applyStimulus(w, sz, sgn, addr, wd);
        waitDone();
        checkOutput({name, "_count"}, 32'(respCount - rc0), 32'd1);
        checkOutput({name, "_data"}, lastRespData, expData);
        checkOutput({name, "_err"}, {31'b0, lastRespErr}, {31'b0, expErr});
        checkOutput({name, "_lat"}, 32'(lastRespCyc + 1 - lastAccept), 32'(expLat));
    endtask

    initial begin : watchdog
        #500_000;
        $display("[TB] FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : mainSeq
        int          rc0;
        int          wc0;
        int          r;
        logic [31:0] a;
        logic [31:0] saved;
        logic [1:0]  s;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]    = $urandom;
            refMem[i] = mem[i];
        end
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("reset_resp_error", {31'b0, resp_error}, 32'd0);
        checkOutput("reset_resp_rdata", resp_rdata, 32'd0);
        checkOutput("reset_data_address", data_address, 32'd0);
        checkOutput("reset_write_data", write_data, 32'd0);
        checkOutput("reset_write_enable", {31'b0, write_enable}, 32'd0);
        #1;
        rst      = 1'b0;
        checking = 1'b1;

        $display("[TB] directed accesses");
        runDirected("st_word", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        checkOutput("st_word_we_addr", lastWeAddr, 32'd4);
        checkOutput("st_word_we_data", lastWeData, 32'hDEADBEEF);
        runDirected("ld_word", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);
        runDirected("ld_byte_s", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2);
        runDirected("ld_half_u", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h0000DEAD, 1'b0, 2);
        runDirected("st_byte", 1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF55, 32'h0, 1'b0, 3);
        checkOutput("st_byte_we_data", lastWeData, 32'hDEAD55EF);

        wc0 = weCount;
        runDirected("err_half", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 1);
        runDirected("err_word", 1'b1, 2'b10, 1'b0, 32'h12, 32'h1234, 32'h0, 1'b1, 1);
        runDirected("err_rsvd", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1);
        runDirected("err_range", 1'b1, 2'b10, 1'b0, 32'h4000, 32'h5555, 32'h0, 1'b1, 1);
        checkOutput("err_no_write", 32'(weCount - wc0), 32'd0);
        checkOutput("err_addr_held", data_address, 32'd4);

        runDirected("st_top", 1'b1, 2'b10, 1'b0, 32'h3FFC, 32'hA5A50F0F, 32'h0, 1'b0, 2);
        runDirected("ld_top", 1'b0, 2'b10, 1'b1, 32'h3FFC, 32'h0, 32'hA5A50F0F, 1'b0, 2);

        $display("[TB] back-to-back loads");
        rc0 = respCount;
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h3FFC, 32'h0);
        waitDone();
        checkOutput("b2b_count", 32'(respCount - rc0), 32'd3);
        checkOutput("b2b_last_data", lastRespData, 32'hA5A50F0F);

        $display("[TB] randomized accesses");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                req_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            r = $urandom_range(0, 15);
            if (r == 0) a = $urandom | 32'h4000;
            else if (r == 1) a = 32'h3FFC | 32'($urandom_range(0, 3));
            else a = 32'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
            r = $urandom_range(0, 9);
            s = (r == 9) ? 2'b11 : 2'(r % 3);
            applyStimulus(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom);
        end
        waitDone();

        $display("[TB] reset during read-modify-write");
        saved = refMem[8];
        rc0   = respCount;
        wc0   = weCount;
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        rst = 1'b1;
        expQ.delete();
        modelAddr = '0;
        @(negedge clk);
        checkOutput("rst_read_no_resp", 32'(respCount - rc0), 32'd0);
        checkOutput("rst_read_no_write", 32'(weCount - wc0), 32'd0);
        checkOutput("rst_read_mem", mem[8], saved);
        checkOutput("rst_read_write_data", write_data, 32'd0);
        checkOutput("rst_read_resp_rdata", resp_rdata, 32'd0);
        checkOutput("rst_read_resp_error", {31'b0, resp_error}, 32'd0);
        #1;
        rst = 1'b0;

        $display("[TB] reset after write cycle");
        rc0 = respCount;
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h30, 32'h12345678);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        rst = 1'b1;
        expQ.delete();
        modelAddr = '0;
        @(negedge clk);
        checkOutput("rst_write_mem", mem[12], 32'h12345678);
        checkOutput("rst_write_no_resp", 32'(respCount - rc0), 32'd0);
        #1;
        rst = 1'b0;
        runDirected("ld_after_rst", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h12345678, 1'b0, 2);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
